// File: rtl/prod_accum.sv
// prod_accum: saturating accumulator of signed products over in_last-delimited frames,
// emitting a rounded, scaled and clipped sum on a held valid/ready output.
module prod_accum #(
    parameter int P_W   = 16,
    parameter int ACC_W = 24,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P_W-1:0]   in_p,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic signed [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   OMAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   OMIN = ~OMAX;
    // Half an output LSB; evaluates to zero when no shift is applied.
    localparam logic [ACC_W:0] RND = (ACC_W+1)'(((ACC_W+2)'(1) << SHIFT) >> 1);

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    ovf;
    logic                    ovf_now;
    logic                    clip_hi;
    logic                    clip_lo;
    logic [ACC_W:0]          add_w;
    logic signed [ACC_W:0]   rnd_w;
    logic signed [ACC_W:0]   r;
    logic [OUT_W-1:0]        sum_clip;

    assign out_valid = (state == HOLD);
    assign in_ready  = (state == ACCUM);

    assign add_w    = {acc[ACC_W-1], acc} + (ACC_W+1)'($signed(in_p));
    assign ovf_now  = add_w[ACC_W] ^ add_w[ACC_W-1];
    assign acc_nxt  = ovf_now ? (add_w[ACC_W] ? ~AMAX : AMAX) : add_w[ACC_W-1:0];
    assign cnt_nxt  = &cnt ? cnt : cnt + CNT_W'(1);
    assign rnd_w    = {acc_nxt[ACC_W-1], acc_nxt} + RND;
    assign r        = rnd_w >>> SHIFT;
    assign clip_hi  = r > OMAX;
    assign clip_lo  = r < OMIN;
    assign sum_clip = clip_hi ? OMAX[OUT_W-1:0] : clip_lo ? OMIN[OUT_W-1:0] : r[OUT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (state == HOLD) begin
            if (out_ready) state <= ACCUM;
        end else if (in_valid && in_last) begin
            state     <= HOLD;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= sum_clip;
            out_count <= cnt_nxt;
            out_sat   <= ovf | ovf_now | clip_hi | clip_lo;
        end else if (in_valid) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf | ovf_now;
        end
    end
endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed checks of prod_accum with SHIFT=0 and SHIFT=4 instances sharing stimulus.
module tb_prod_accum;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_p;
    logic        in_last;
    logic        out_ready;
    logic        in_ready0, out_valid0, out_sat0;
    logic        in_ready4, out_valid4, out_sat4;
    logic [15:0] out_sum0, out_sum4;
    logic [7:0]  out_count0, out_count4;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    prod_accum dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_p(in_p), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
        .out_sum(out_sum0), .out_count(out_count0), .out_sat(out_sat0)
    );

    prod_accum #(.SHIFT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_p(in_p), .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready),
        .out_sum(out_sum4), .out_count(out_count4), .out_sat(out_sat4)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic signed [15:0] p, input logic last);
        in_valid = 1'b1;
        in_p     = p;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("take_valid", 32'(out_valid0), 32'sd0);
        check("take_ready", 32'(in_ready0), 32'sd1);
    endtask

    task automatic result0(input string tag, input int sum, input int count, input int sat);
        check({tag, "_valid"}, 32'(out_valid0), 32'sd1);
        check({tag, "_sum"}, 32'($signed(out_sum0)), sum);
        check({tag, "_count"}, 32'(out_count0), count);
        check({tag, "_sat"}, 32'(out_sat0), sat);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_p = '0; in_last = 1'b0; out_ready = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid0), 32'sd0);
        check("rst_sum", 32'($signed(out_sum0)), 32'sd0);
        check("rst_count", 32'(out_count0), 32'sd0);
        check("rst_sat", 32'(out_sat0), 32'sd0);
        check("rst_ready", 32'(in_ready0), 32'sd1);

        send(16'sd100, 1'b0);
        check("mid_valid", 32'(out_valid0), 32'sd0);
        send(-16'sd250, 1'b0);
        send(16'sd30, 1'b1);
        result0("f3", -120, 3, 0);
        check("f3_ready", 32'(in_ready0), 32'sd0);
        take();

        send(-16'sd32768, 1'b1);
        result0("min1", -32768, 1, 0);
        take();
        send(16'sd32767, 1'b1);
        result0("max1", 32767, 1, 0);
        take();

        for (int i = 0; i < 4; i++) send(16'sd32767, i == 3);
        result0("clip_hi", 32767, 4, 1);
        take();
        for (int i = 0; i < 4; i++) send(-16'sd32768, i == 3);
        result0("clip_lo", -32768, 4, 1);
        take();

        for (int i = 0; i < 300; i++) send(16'sd32767, i == 299);
        result0("acc_sat", 32767, 255, 1);
        take();

        send(16'sd24, 1'b1);
        check("rnd_pos", 32'($signed(out_sum4)), 32'sd2);
        check("rnd_pos_sat", 32'(out_sat4), 32'sd0);
        take();
        send(-16'sd24, 1'b1);
        check("rnd_neg", 32'($signed(out_sum4)), -32'sd1);
        take();

        send(16'sd24, 1'b1);
        in_valid = 1'b1; in_p = 16'sd7; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(out_valid4), 32'sd1);
            check("bp_ready", 32'(in_ready4), 32'sd0);
            check("bp_sum", 32'($signed(out_sum4)), 32'sd2);
            check("bp_count", 32'(out_count4), 32'sd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bubble_valid", 32'(out_valid4), 32'sd0);
        check("bubble_ready", 32'(in_ready4), 32'sd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        check("bp7_sum4", 32'($signed(out_sum4)), 32'sd0);
        result0("bp7", 7, 1, 0);
        take();
        repeat (2) @(posedge clk);
        #1;
        check("bp7_once", 32'(out_valid0), 32'sd0);

        send(16'sd500, 1'b0);
        send(16'sd600, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid0), 32'sd0);
        check("arst_ready", 32'(in_ready0), 32'sd1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'sd7, 1'b1);
        result0("after_rst", 7, 1, 0);
        take();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prod_accum.md
# prod_accum

Signed product accumulator that sits directly downstream of the sequential signed multiplier. It consumes one signed product per valid/ready beat, sums a frame of products delimited by `in_last` in a saturating wide accumulator, then scales, rounds and saturates the sum to `OUT_W` bits. The frame result is presented on a held valid/ready output together with a beat count and a saturation flag. Together with the multiplier it forms a sequential dot-product / FIR tap-sum path.

## Interface
- `P_W`, default 16: product width; matches the multiplier's `A_W+B_W`.
- `ACC_W`, default 24: accumulator width. Must satisfy `ACC_W >= P_W`.
- `OUT_W`, default 16: result width. Must satisfy `OUT_W <= ACC_W`.
- `SHIFT`, default 0: arithmetic right shift applied to the final sum. Range 0 to `ACC_W-1`.
- `CNT_W`, default 8: width of the beat counter.

Ports:
- `clk`, in, 1: the single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: product beat valid.
- `in_ready`, out, 1: block can accept a beat.
- `in_p`, in, `P_W`: signed product.
- `in_last`, in, 1: this beat closes the frame.
- `out_valid`, out, 1: frame result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_sum`, out, `OUT_W`: signed, scaled and saturated frame sum.
- `out_count`, out, `CNT_W`: number of beats in the frame; saturates at all-ones.
- `out_sat`, out, 1: accumulator saturated, or output clipped, during this frame.

## Operation
- States:
  - ACCUM (`out_valid=0`).
  - HOLD (`out_valid=1`).
- `in_ready = ~out_valid`. It is driven from a register only, with no combinational path from `out_ready`.
- Accepted beat (`in_valid & in_ready`):
  - `in_p` is sign-extended to `ACC_W` and added to `acc`.
  - If the signed add overflows, `acc` clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1), and sticky flag `ovf` is set.
  - `cnt` increments, saturating at 2^CNT_W-1.
- Accepted beat with `in_last=1`:
  - The final sum is `acc` plus this beat (including any clamping).
  - Rounding:
    - If `SHIFT>0`: `r = (sum + 2^(SHIFT-1)) >>> SHIFT`, computed in `ACC_W+1` bits (round half toward +inf).
    - If `SHIFT=0`: `r = sum`.
  - Output register load:
    - `out_sum` = `r` clipped to the `OUT_W` signed range.
    - `out_count` = `cnt+1`, saturated.
    - `out_sat` = `ovf` OR (clamp on this beat) OR (clip occurred).
  - Then `acc`, `cnt` and `ovf` clear and the block enters HOLD.
- HOLD:
  - `out_sum`, `out_count` and `out_sat` stay stable.
  - No input is accepted.
  - `out_valid & out_ready` returns the block to ACCUM.
- A frame of exactly one beat (`in_last` on the first beat) is legal.
- There is no empty frame: a result is produced only on an accepted `in_last` beat.
- Reset, asynchronous and valid at any time including mid-frame:
  - `acc`, `cnt`, `ovf` clear and the block enters ACCUM.
  - `out_valid=0`, `out_sum=0`, `out_count=0`, `out_sat=0`; hence `in_ready=1`.
  - A partial frame in progress is discarded.

## Timing
- Throughput: one beat per cycle while in ACCUM.
- Latency: a `last` beat accepted at edge k gives `out_valid=1` in the cycle after edge k.
- `in_ready` falls in that same cycle.
- Result accepted at edge m gives `out_valid=0` and `in_ready=1` in the cycle after edge m. This is one bubble cycle per frame.
- `in_valid` asserted during HOLD is not consumed. The upstream multiplier must hold its `p`/`out_valid`, which it already does.
- `in_p` and `in_last` are ignored whenever `in_valid=0`.

## Test plan
- Reset with defaults:
  - Check `out_valid=0`, `out_sum=0`, `out_count=0`, `out_sat=0`, `in_ready=1`.
  - Send beats 100, -250, 30 (last) back-to-back → `out_sum=-120`, `out_count=3`, `out_sat=0`, `out_valid` high one cycle after the last beat.
- Single-beat frame, `in_p=-32768` last → `out_sum=-32768`, `out_count=1`, `out_sat=0`. Then a single beat 32767 last → `out_sum=32767`, `out_count=1`, `out_sat=0`.
- Output clip: 4 beats of 32767 → sum 131068 clips to `out_sum=32767`, `out_sat=1`, `out_count=4`. 4 beats of -32768 → `out_sum=-32768`, `out_sat=1`.
- Accumulator and counter saturation: 300 beats of 32767, last on beat 300 → `acc` clamps at 8388607, `out_sum=32767`, `out_sat=1`, `out_count=255`.
- Backpressure and rounding (`SHIFT=4` instance):
  - Frame sum 24 → `out_sum=2`. Frame sum -24 → `out_sum=-1`.
  - Hold `out_ready=0` for 5 cycles while `in_valid=1` with beat 7: outputs stay stable, `in_ready=0`, no beat accepted.
  - After `out_ready` is released, beat 7 is accepted exactly once.
- Reset mid-frame: accept 500 and 600, pulse `rst_n` low asynchronously between edges, then send 7 last → `out_sum=7`, `out_count=1`, `out_sat=0`.
